// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with look-ahead pixel requests and registered, aligned sync/DE/RGB.
// Optional colour-bar test pattern enabled by defining VGA_TEST_PATTERN_EN (adds input tp_en).
module vga_timing_gen #(
  parameter int   H_SYNC      = 128,
  parameter int   H_BP        = 88,
  parameter int   H_ACTIVE    = 800,
  parameter int   H_FP        = 40,
  parameter int   V_SYNC      = 4,
  parameter int   V_BP        = 23,
  parameter int   V_ACTIVE    = 600,
  parameter int   V_FP        = 1,
  parameter logic HS_POL      = 1'b0,
  parameter logic VS_POL      = 1'b0,
  parameter int   RGB_W       = 24,
  parameter int   PIX_LATENCY = 1,
  parameter int   CNT_W       = 11
) (
  input  logic             clk_40mhz,
  input  logic             rst,
  input  logic [RGB_W-1:0] pix_data,
`ifdef VGA_TEST_PATTERN_EN
  input  logic             tp_en,
`endif
  output logic             req_valid,
  output logic [CNT_W-1:0] req_x,
  output logic [CNT_W-1:0] req_y,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_de,
  output logic [RGB_W-1:0] vga_rgb,
  output logic             frame_start,
  output logic             line_start,
  output logic             vblank,
  output logic [15:0]      frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int STAGES  = PIX_LATENCY + 1;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_S  = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_ACT_E  = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_S  = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_ACT_E  = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic [15:0]      frame_q;

  always_ff @(posedge clk_40mhz) begin
    if (rst) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      frame_q <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      if (v_cnt == V_LAST) begin
        v_cnt   <= '0;
        frame_q <= frame_q + 16'd1;
      end else begin
        v_cnt <= v_cnt + CNT_W'(1);
      end
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  // Request stage: combinational view of the current counter position.
  logic h_act, v_act, hs_d, vs_d;

  always_comb begin
    h_act       = (h_cnt >= H_ACT_S) && (h_cnt < H_ACT_E);
    v_act       = (v_cnt >= V_ACT_S) && (v_cnt < V_ACT_E);
    req_valid   = h_act && v_act;
    req_x       = req_valid ? (h_cnt - H_ACT_S) : '0;
    req_y       = req_valid ? (v_cnt - V_ACT_S) : '0;
    frame_start = (h_cnt == '0) && (v_cnt == '0);
    line_start  = (h_cnt == '0);
    vblank      = !v_act;
    hs_d        = (h_cnt < H_SYNC_E) ? HS_POL : ~HS_POL;
    vs_d        = (v_cnt < V_SYNC_E) ? VS_POL : ~VS_POL;
  end

  // Index 0 of de_all is the live request; index PIX_LATENCY lines up with pix_data.
  logic [STAGES:1] hs_q, vs_q, de_q;
  logic [STAGES:0] de_all;
  logic [RGB_W-1:0] rgb_q, pix_sel;

  assign de_all = {de_q, req_valid};

`ifdef VGA_TEST_PATTERN_EN
  localparam int COMP_W = RGB_W / 3;
  localparam logic [CNT_W-1:0] BAR_W = CNT_W'((H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1);

  logic [CNT_W-1:0] bar_quot;
  logic [2:0]       bar_d, bar_tap;

  // Bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0].
  function automatic logic [RGB_W-1:0] bar_rgb(input logic [2:0] idx);
    logic [RGB_W-1:0] c;
    c = '0;
    for (int i = 0; i < COMP_W; i++) begin
      c[2*COMP_W+i] = ~idx[1];
      c[COMP_W+i]   = ~idx[2];
      c[i]          = ~idx[0];
    end
    return c;
  endfunction

  assign bar_quot = req_x / BAR_W;
  assign bar_d    = (bar_quot > CNT_W'(7)) ? 3'd7 : bar_quot[2:0];

  if (PIX_LATENCY == 0) begin : g_bar0
    assign bar_tap = bar_d;
  end else begin : g_barn
    logic [PIX_LATENCY:1][2:0] bar_q;
    always_ff @(posedge clk_40mhz) begin
      if (rst) begin
        bar_q <= '0;
      end else begin
        bar_q[1] <= bar_d;
        for (int i = 2; i <= PIX_LATENCY; i++) bar_q[i] <= bar_q[i-1];
      end
    end
    assign bar_tap = bar_q[PIX_LATENCY];
  end

  assign pix_sel = tp_en ? bar_rgb(bar_tap) : pix_data;
`else
  assign pix_sel = pix_data;
`endif

  always_ff @(posedge clk_40mhz) begin
    if (rst) begin
      hs_q  <= {STAGES{~HS_POL}};
      vs_q  <= {STAGES{~VS_POL}};
      de_q  <= '0;
      rgb_q <= '0;
    end else begin
      hs_q[1] <= hs_d;
      vs_q[1] <= vs_d;
      de_q[1] <= req_valid;
      for (int i = 2; i <= STAGES; i++) begin
        hs_q[i] <= hs_q[i-1];
        vs_q[i] <= vs_q[i-1];
        de_q[i] <= de_q[i-1];
      end
      rgb_q <= de_all[PIX_LATENCY] ? pix_sel : '0;
    end
  end

  assign vga_hs    = hs_q[STAGES];
  assign vga_vs    = vs_q[STAGES];
  assign vga_de    = de_q[STAGES];
  assign vga_rgb   = rgb_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen on a small raster; expected values come from raster arithmetic on cycles since reset.
module tb_vga_timing_gen;
  localparam int   HS = 5, HB = 3, HA = 16, HF = 4;
  localparam int   VS = 2, VB = 2, VA = 5, VF = 1;
  localparam int   HT = HS + HB + HA + HF;   // 28
  localparam int   VT = VS + VB + VA + VF;   // 10
  localparam int   FR = HT * VT;             // 280
  localparam int   LAT = 3, RW = 24, CW = 11;
  localparam logic HPOL = 1'b1, VPOL = 1'b0;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] pix_data;
  logic          req_valid, vga_hs, vga_vs, vga_de, frame_start, line_start, vblank;
  logic [CW-1:0] req_x, req_y;
  logic [RW-1:0] vga_rgb;
  logic [15:0]   frame_cnt;
`ifdef VGA_TEST_PATTERN_EN
  logic          tp_en = 1'b0;
`endif

  vga_timing_gen #(
    .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
    .HS_POL(HPOL), .VS_POL(VPOL), .RGB_W(RW), .PIX_LATENCY(LAT), .CNT_W(CW)
  ) dut (
    .clk_40mhz(clk), .rst(rst), .pix_data(pix_data),
`ifdef VGA_TEST_PATTERN_EN
    .tp_en(tp_en),
`endif
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de), .vga_rgb(vga_rgb),
    .frame_start(frame_start), .line_start(line_start), .vblank(vblank),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int acnt = 0, fcnt = 0;
  int t = 0;
  bit run = 1'b0;
  logic [RW-1:0] pix_last = '0;
  int de_n, hs_hi, vs_lo;

  task automatic chk(input string nm, input longint act, input longint exp);
    acnt++;
    if (act != exp) begin
      fcnt++;
      $display("FAIL %s t=%0d actual=%0d expected=%0d", nm, t, act, exp);
    end
  endtask

  function automatic bit is_act(input int h, input int v);
    return (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
  endfunction

  // t = cycles since the last reset edge, i.e. raster position index of the request stage.
  always @(posedge clk) begin
    if (rst) begin
      t   = 0;
      run = 1'b1;
    end else if (run) begin
      t++;
    end
    pix_last = pix_data;
  end

  always @(negedge clk) begin
    int h, v, p, ph, pv;
    bit a, ehs, evs, ede;
    logic [RW-1:0] ergb;
    if (run) begin
      h = t % HT;
      v = (t / HT) % VT;
      a = is_act(h, v);
      chk("req_valid", req_valid, a);
      chk("req_x", req_x, a ? h - (HS + HB) : 0);
      chk("req_y", req_y, a ? v - (VS + VB) : 0);
      chk("frame_start", frame_start, (h == 0) && (v == 0));
      chk("line_start", line_start, h == 0);
      chk("vblank", vblank, !((v >= VS + VB) && (v < VS + VB + VA)));
      chk("frame_cnt", frame_cnt, (t / FR) % 65536);

      if (t < LAT + 1) begin
        ehs = ~HPOL; evs = ~VPOL; ede = 1'b0; ergb = '0;
      end else begin
        p    = t - (LAT + 1);
        ph   = p % HT;
        pv   = (p / HT) % VT;
        ehs  = (ph < HS) ? HPOL : ~HPOL;
        evs  = (pv < VS) ? VPOL : ~VPOL;
        ede  = is_act(ph, pv);
        ergb = ede ? pix_last : '0;
      end
      chk("vga_hs", vga_hs, ehs);
      chk("vga_vs", vga_vs, evs);
      chk("vga_de", vga_de, ede);
      chk("vga_rgb", vga_rgb, ergb);

      // Per-frame output totals over one full frame of output cycles.
      if (t == 0) begin de_n = 0; hs_hi = 0; vs_lo = 0; end
      if (t >= LAT + 1 && t < LAT + 1 + FR) begin
        de_n  += int'(vga_de);
        hs_hi += int'(vga_hs);
        vs_lo += int'(!vga_vs);
      end
      if (t == LAT + 1 + FR) begin
        chk("de_per_frame", de_n, 80);
        chk("hs_high_per_frame", hs_hi, 50);
        chk("vs_low_per_frame", vs_lo, 56);
      end

      // Hand-computed anchors for this geometry.
      if (t == 0)   chk("lit_frame_start0", frame_start, 1);
      if (t == 3)   chk("lit_hs_still_idle", vga_hs, 0);
      if (t == 4)   chk("lit_hs_first_sync", vga_hs, 1);
      if (t == 120) begin
        chk("lit_first_valid", req_valid, 1);
        chk("lit_first_x", req_x, 0);
        chk("lit_first_y", req_y, 0);
      end
      if (t == 247) begin
        chk("lit_last_x", req_x, 15);
        chk("lit_last_y", req_y, 4);
      end
      if (t == 248) begin
        chk("lit_past_active_valid", req_valid, 0);
        chk("lit_past_active_x", req_x, 0);
      end
      if (t == 560) chk("lit_two_frames", frame_cnt, 2);
    end
  end

  task automatic drive(input int n);
    repeat (n) begin
      pix_data = RW'($urandom);
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    pix_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive(700);
    for (int k = 0; k < 6; k++) begin
      rst = 1'b1;
      drive(1);
      rst = 1'b0;
      drive(int'($urandom_range(30, 450)));
    end
    rst = 1'b1;
    drive(2);
    rst = 1'b0;
    drive(300);
    $display("End of test - %0d assertions evaluated, %0d failures", acnt, fcnt);
    $finish;
  end
endmodule
